ring_mem_requester: RTL

//  Station-side initiator for the memory ring. Queues line read/write requests from a core.
//  On token capture, injects an Address slot, plus four WriteData slots for writes, then releases the Token.

---
 rtl/ring_mem_requester.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ring_mem_requester.sv
// Station-side memory-ring initiator: queues core line requests, injects Address/WriteData
// slots while holding the token, and assembles four-word read returns into one line.
module ring_mem_requester #(
    parameter logic [3:0]  STATION_ID    = 4'd1,
    parameter int unsigned QDEPTH        = 4,
    parameter int unsigned MAX_PER_TOKEN = 2,
    parameter int unsigned RD_TIMEOUT    = 1023
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  RingIn,
    input  logic [3:0]   SlotTypeIn,
    input  logic [3:0]   SourceIn,
    output logic [31:0]  RingOut,
    output logic [3:0]   SlotTypeOut,
    output logic [3:0]   SourceOut,
    input  logic [31:0]  RDreturn,
    input  logic [3:0]   RDdest,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic         reqWrite,
    input  logic [25:0]  reqAddr,
    input  logic [127:0] reqWdata,
    output logic         rdValid,
    output logic [127:0] rdData,
    output logic         rdBusy,
    output logic         rdTimeout,
    output logic         protoErr
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(MAX_PER_TOKEN + 1);
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;
    localparam logic [3:0] SLOT_NULL  = 4'd7;

    typedef struct packed {
        logic         write;
        logic [25:0]  addr;
        logic [127:0] wdata;
    } req_t;

    // The NEXT decision is folded into the last ADDR/WDATA cycle so the following slot leaves without a bubble.
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA} state_t;

    req_t              mem_q [QDEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_t            state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [IW-1:0]     issued_q, issued_d;
    logic [2:0][31:0]  wbuf_q, wbuf_d;
    logic [31:0]       ring_out_q, ring_out_d;
    logic [3:0]        slot_out_q, slot_out_d;
    logic [3:0]        src_out_q, src_out_d;
    logic              req_ready_q, req_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [127:0]      rd_data_q, rd_data_d;
    logic              rd_busy_q, rd_busy_d;
    logic              rd_timeout_q, rd_timeout_d;
    logic              proto_err_q, proto_err_d;
    logic [1:0]        rcnt_q, rcnt_d;
    logic [2:0][31:0]  rbuf_q, rbuf_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    req_t              head;
    logic              nxt_write;
    logic [25:0]       nxt_addr;
    logic              head_ok, nxt_ok;
    logic              cand_write, cand_ok;
    logic [25:0]       cand_addr;
    logic              push, pop, take_next, emit_addr, emit_token;

    assign head      = mem_q[rd_ptr_q];
    assign nxt_write = mem_q[rd_ptr_q + AW'(1)].write;
    assign nxt_addr  = mem_q[rd_ptr_q + AW'(1)].addr;

    // A read head is only eligible when no read is outstanding; the entry behind a popped read sees rdBusy set.
    assign head_ok    = (count_q != CW'(0)) && (head.write || !rd_busy_q);
    assign nxt_ok     = (count_q >= CW'(2)) && nxt_write;
    assign cand_write = (state_q == S_ADDR) ? nxt_write : head.write;
    assign cand_addr  = (state_q == S_ADDR) ? nxt_addr  : head.addr;
    assign cand_ok    = (state_q == S_ADDR) ? nxt_ok    : head_ok;

    assign push = reqValid && req_ready_q;
    assign pop  = (state_q == S_ADDR);

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        issued_d     = issued_q;
        wbuf_d       = wbuf_q;
        ring_out_d   = RingIn;
        slot_out_d   = SlotTypeIn;
        src_out_d    = SourceIn;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_busy_d    = rd_busy_q;
        rd_timeout_d = rd_timeout_q;
        proto_err_d  = proto_err_q;
        rcnt_d       = rcnt_q;
        rbuf_d       = rbuf_q;
        tmo_d        = tmo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        take_next    = 1'b0;
        emit_addr    = 1'b0;
        emit_token   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (SlotTypeIn == SLOT_TOKEN && head_ok) begin
                    emit_addr = 1'b1;
                    issued_d  = IW'(1);
                end
            end
            S_ADDR: begin
                if (head.write) begin
                    ring_out_d = head.wdata[31:0];
                    slot_out_d = SLOT_WDATA;
                    src_out_d  = STATION_ID;
                    wbuf_d     = head.wdata[127:32];
                    wcnt_d     = 2'd0;
                    state_d    = S_WDATA;
                end else begin
                    rd_busy_d = 1'b1;
                    take_next = 1'b1;
                end
            end
            S_WDATA: begin
                if (wcnt_q != 2'd3) begin
                    case (wcnt_q)
                        2'd0:    ring_out_d = wbuf_q[0];
                        2'd1:    ring_out_d = wbuf_q[1];
                        default: ring_out_d = wbuf_q[2];
                    endcase
                    slot_out_d = SLOT_WDATA;
                    src_out_d  = STATION_ID;
                    wcnt_d     = wcnt_q + 2'd1;
                end else begin
                    take_next = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_next) begin
            if (cand_ok && (issued_q < IW'(MAX_PER_TOKEN))) begin
                emit_addr = 1'b1;
                issued_d  = issued_q + IW'(1);
            end else begin
                emit_token = 1'b1;
            end
        end

        if (emit_addr) begin
            ring_out_d = {3'b000, !cand_write, 2'b00, cand_addr};
            slot_out_d = SLOT_ADDR;
            src_out_d  = STATION_ID;
            state_d    = S_ADDR;
        end
        if (emit_token) begin
            ring_out_d = 32'd0;
            slot_out_d = SLOT_TOKEN;
            src_out_d  = 4'd0;
            state_d    = S_IDLE;
        end

        // Any live slot arriving while the token is held gets overwritten.
        if (state_q != S_IDLE && SlotTypeIn != SLOT_NULL) begin
            proto_err_d = 1'b1;
        end

        if (RDdest == STATION_ID) begin
            if (rd_busy_q) begin
                if (rcnt_q == 2'd3) begin
                    rd_data_d  = {RDreturn, rbuf_q[2], rbuf_q[1], rbuf_q[0]};
                    rd_valid_d = 1'b1;
                    rd_busy_d  = 1'b0;
                    rcnt_d     = 2'd0;
                end else begin
                    case (rcnt_q)
                        2'd0:    rbuf_d[0] = RDreturn;
                        2'd1:    rbuf_d[1] = RDreturn;
                        default: rbuf_d[2] = RDreturn;
                    endcase
                    rcnt_d = rcnt_q + 2'd1;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end

        // Timeout counter saturates at the limit; completion or idle clears it.
        if (!rd_busy_q || !rd_busy_d) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(RD_TIMEOUT)) begin
            tmo_d = tmo_q + TW'(1);
            if (tmo_d == TW'(RD_TIMEOUT)) begin
                rd_timeout_d = 1'b1;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d     = count_q + CW'(push) - CW'(pop);
        req_ready_d = (count_d != CW'(QDEPTH));
    end

    // Request storage; validity is tracked solely by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: reqWrite, addr: reqAddr, wdata: reqWdata};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            wcnt_q       <= 2'd0;
            issued_q     <= '0;
            wbuf_q       <= '0;
            ring_out_q   <= 32'd0;
            slot_out_q   <= SLOT_NULL;
            src_out_q    <= 4'd0;
            req_ready_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_busy_q    <= 1'b0;
            rd_timeout_q <= 1'b0;
            proto_err_q  <= 1'b0;
            rcnt_q       <= 2'd0;
            rbuf_q       <= '0;
            tmo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            issued_q     <= issued_d;
            wbuf_q       <= wbuf_d;
            ring_out_q   <= ring_out_d;
            slot_out_q   <= slot_out_d;
            src_out_q    <= src_out_d;
            req_ready_q  <= req_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_busy_q    <= rd_busy_d;
            rd_timeout_q <= rd_timeout_d;
            proto_err_q  <= proto_err_d;
            rcnt_q       <= rcnt_d;
            rbuf_q       <= rbuf_d;
            tmo_q        <= tmo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign RingOut     = ring_out_q;
    assign SlotTypeOut = slot_out_q;
    assign SourceOut   = src_out_q;
    assign reqReady    = req_ready_q;
    assign rdValid     = rd_valid_q;
    assign rdData      = rd_data_q;
    assign rdBusy      = rd_busy_q;
    assign rdTimeout   = rd_timeout_q;
    assign protoErr    = proto_err_q;

endmodule
